// File: rtl/multi_channel_result_checker.sv
// Result checker: snoops data-memory writes to NUM_CH test ports and
// compares each channel's stream against a preloaded golden table.
module multi_channel_result_checker #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7,
    parameter logic [ADDR_W-1:0] TEST_BASE = 'h40,
    parameter logic [DATA_W-1:0] BEGIN_SYM = 'h932,
    parameter int ERR_W = 8,
    parameter int DUR_W = 16,
    parameter logic [DUR_W-1:0] TIMEOUT = {DUR_W{1'b1}},
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              gold_we,
    input  logic [CH_W-1:0]   gold_ch,
    input  logic [IDX_W-1:0]  gold_idx,
    input  logic [DATA_W-1:0] gold_data,
    input  logic [IDX_W:0]    check_num,
    output logic [ERR_W-1:0]  error_num,
    output logic [DUR_W-1:0]  duration,
    output logic              finish,
    output logic              pass,
    output logic              timeout,
    output logic              first_err_vld,
    output logic [CH_W-1:0]   first_err_ch,
    output logic [IDX_W-1:0]  first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REPORT
    } state_e;

    localparam logic [ERR_W-1:0] ERR_SAT = {{(ERR_W-1){1'b1}}, 1'b0};
    localparam logic [IDX_W:0]   DEPTH_N = (IDX_W+1)'(DEPTH);

    state_e            state_q;
    logic              wen_q;
    logic [ERR_W-1:0]  err_q;
    logic [ERR_W-1:0]  err_d;
    logic [DUR_W-1:0]  dur_q;
    logic [DUR_W-1:0]  dur_d;
    logic [IDX_W:0]    num_q;
    logic [IDX_W:0]    num_d;
    logic [IDX_W:0]    idx_q [NUM_CH];
    logic              timeout_q;
    logic              fvld_q;
    logic [CH_W-1:0]   fch_q;
    logic [IDX_W-1:0]  fidx_q;
    logic [DATA_W-1:0] gold_q [NUM_CH][DEPTH];

    logic              acc;
    logic              hit;
    logic [CH_W-1:0]   hit_ch;
    logic [IDX_W:0]    cur_idx;
    logic              in_range;
    logic              mismatch;
    logic              all_done;
    logic              begin_hit;

    // A write held high across stall cycles is only taken on its first cycle.
    assign acc = wen & ~wen_q;

    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr == TEST_BASE + ADDR_W'(c)) begin
                hit    = 1'b1;
                hit_ch = CH_W'(c);
            end
        end
    end

    always_comb begin
        all_done = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (idx_q[c] != num_q) begin
                all_done = 1'b0;
            end
        end
    end

    assign begin_hit = acc & (addr == TEST_BASE) & (data == BEGIN_SYM);
    assign cur_idx   = idx_q[hit_ch];
    assign in_range  = cur_idx < num_q;
    assign mismatch  = data != gold_q[hit_ch][cur_idx[IDX_W-1:0]];
    assign num_d     = (check_num > DEPTH_N) ? DEPTH_N : check_num;
    assign err_d     = (err_q == ERR_SAT) ? err_q : err_q + 1'b1;
    assign dur_d     = dur_q + 1'b1;

    // Golden table survives reset so a preload can be reused across runs.
    always_ff @(posedge clk) begin
        if (gold_we && state_q == S_IDLE &&
            {1'b0, gold_ch} < (CH_W+1)'(NUM_CH)) begin
            gold_q[gold_ch][gold_idx] <= gold_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wen_q     <= 1'b0;
            err_q     <= '1;
            dur_q     <= '0;
            num_q     <= '0;
            timeout_q <= 1'b0;
            fvld_q    <= 1'b0;
            fch_q     <= '0;
            fidx_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                idx_q[c] <= '0;
            end
        end else begin
            wen_q <= wen;
            unique case (state_q)
                S_IDLE, S_REPORT: begin
                    if (begin_hit) begin
                        state_q   <= S_CHECK;
                        err_q     <= '0;
                        dur_q     <= '0;
                        num_q     <= num_d;
                        timeout_q <= 1'b0;
                        fvld_q    <= 1'b0;
                        fch_q     <= '0;
                        fidx_q    <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            idx_q[c] <= '0;
                        end
                    end
                end
                S_CHECK: begin
                    dur_q <= dur_d;
                    if (all_done) begin
                        state_q <= S_REPORT;
                    end else if (dur_d == TIMEOUT) begin
                        state_q   <= S_REPORT;
                        timeout_q <= 1'b1;
                    end
                    if (acc && hit) begin
                        if (in_range) begin
                            idx_q[hit_ch] <= cur_idx + 1'b1;
                        end
                        // Overruns count as errors but leave the index parked.
                        if (!in_range || mismatch) begin
                            err_q <= err_d;
                            if (!fvld_q) begin
                                fvld_q <= 1'b1;
                                fch_q  <= hit_ch;
                                fidx_q <= cur_idx[IDX_W-1:0];
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign error_num     = err_q;
    assign duration      = dur_q;
    assign finish        = (state_q == S_REPORT);
    assign pass          = finish & (err_q == '0) & ~timeout_q;
    assign timeout       = timeout_q;
    assign first_err_vld = fvld_q;
    assign first_err_ch  = fch_q;
    assign first_err_idx = fidx_q;

endmodule
